// File: rtl/aes_reg_sequencer.sv
// aes_reg_sequencer: moves key/message from the register file into the AES core and writes the result back
module aes_reg_sequencer #(
    parameter logic [4:0] KEY_BASE   = 5'd0,
    parameter logic [4:0] MSG_BASE   = 5'd4,
    parameter logic [4:0] RES_BASE   = 5'd8,
    parameter logic [4:0] START_ADDR = 5'd14,
    parameter logic [4:0] DONE_ADDR  = 5'd15
) (
    input  logic         Clk,
    input  logic         Reset,
    output logic [4:0]   reg_select,
    output logic         reg_ld,
    output logic [31:0]  reg_wdata,
    input  logic [31:0]  reg_rdata,
    output logic [127:0] aes_key,
    output logic [127:0] aes_msg,
    output logic         aes_start,
    input  logic         aes_done,
    input  logic [127:0] aes_result,
    output logic         busy
);
    typedef enum logic [3:0] {IDLE, RD_KEY, RD_MSG, START, WAIT, WR_RES, WR_DONE, DONE, CLR_DONE} state_t;
    state_t        state;
    logic [1:0]    idx;
    logic [127:0]  res_buf;
    // Sequencer state, word counter and data capture; words shift in so word 0 ends up in the top bits
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            idx     <= 2'd0;
            aes_key <= '0;
            aes_msg <= '0;
            res_buf <= '0;
        end else begin
            idx <= 2'd0;
            case (state)
                IDLE:     if (reg_rdata[0]) state <= RD_KEY;
                RD_KEY: begin
                    idx     <= idx + 2'd1;
                    aes_key <= {aes_key[95:0], reg_rdata};
                    if (idx == 2'd3) state <= RD_MSG;
                end
                RD_MSG: begin
                    idx     <= idx + 2'd1;
                    aes_msg <= {aes_msg[95:0], reg_rdata};
                    if (idx == 2'd3) state <= START;
                end
                START:    state <= WAIT;
                WAIT: if (aes_done) begin
                    res_buf <= aes_result;
                    state   <= WR_RES;
                end
                WR_RES: begin
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) state <= WR_DONE;
                end
                WR_DONE:  state <= DONE;
                DONE:     if (!reg_rdata[0]) state <= CLR_DONE;
                CLR_DONE: state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end
    assign busy       = state != IDLE;
    assign aes_start  = state == START;
    assign reg_ld     = state inside {WR_RES, WR_DONE, CLR_DONE};
    assign reg_select = state == RD_KEY ? KEY_BASE + {3'b0, idx} :
                        state == RD_MSG ? MSG_BASE + {3'b0, idx} :
                        state == WR_RES ? RES_BASE + {3'b0, idx} :
                        (state == WR_DONE || state == CLR_DONE) ? DONE_ADDR : START_ADDR;
    assign reg_wdata  = state == WR_RES ? res_buf[{~idx, 5'd0} +: 32] : {31'd0, state == WR_DONE};
endmodule

// File: doc/aes_reg_sequencer.md
Name: aes_reg_sequencer

Overview:
- Control sequencer between the 16-word x 32-bit AES register file and the AES core.
- Polls a software start word in the register file, then reads the 128-bit key and 128-bit message as four 32-bit words each.
- Pulses the AES core start, waits for completion, then writes the 128-bit result back as four words and sets a done word.
- Owns the register-file port (select, load, write data) and consumes its combinational read data.

Parameters:
- KEY_BASE, 0: word address of key word 0. Key occupies KEY_BASE..KEY_BASE+3.
- MSG_BASE, 4: word address of message word 0. Message occupies MSG_BASE..+3.
- RES_BASE, 8: word address of result word 0. Result occupies RES_BASE..+3.
- START_ADDR, 14: start word. Bit 0 = go.
- DONE_ADDR, 15: done word. The block writes 32'h1 or 32'h0 here.

Ports:
- Clk, in, 1: single clock, rising edge.
- Reset, in, 1: synchronous, active-high reset.
- reg_select, out, 5: register-file word address.
- reg_ld, out, 1: register-file write enable.
- reg_wdata, out, 32: register-file write data.
- reg_rdata, in, 32: register-file read data, combinational from reg_select.
- aes_key, out, 128: assembled key.
- aes_msg, out, 128: assembled message.
- aes_start, out, 1: one-cycle start pulse to the AES core.
- aes_done, in, 1: AES core completion.
- aes_result, in, 128: AES core output, valid when aes_done=1.
- busy, out, 1: high whenever state != IDLE.

Behaviour:
- Reset: state=IDLE, idx=0, aes_key=0, aes_msg=0, result buffer=0. Outputs: aes_start=0, reg_ld=0, reg_wdata=0, reg_select=START_ADDR, busy=0.
- Reset mid-operation aborts immediately. The next cycle is IDLE with no further register writes.
- Word order is big-endian: word base+0 = bits [127:96], word base+3 = bits [31:0]. The same order applies to key, message and result.
- reg_select, reg_ld, reg_wdata and aes_start are decoded from state and idx.
- idx is a 2-bit counter. It clears on every state entry and advances each cycle in the RD_KEY, RD_MSG and WR_RES states.
- IDLE:
  - Drives select=START_ADDR, ld=0.
  - If reg_rdata[0]=1, go to RD_KEY. Otherwise stay.
- RD_KEY (4 cycles):
  - select=KEY_BASE+idx; capture reg_rdata into key word idx at the clock edge.
  - After idx=3, go to RD_MSG.
- RD_MSG (4 cycles): same as RD_KEY using MSG_BASE. After idx=3, go to START.
- START (1 cycle): aes_start=1, then go to WAIT.
- WAIT:
  - aes_start=0, select=START_ADDR, ld=0.
  - When aes_done=1, latch aes_result into the result buffer and go to WR_RES.
  - aes_done is ignored in every other state. There is no timeout.
- WR_RES (4 cycles): ld=1, select=RES_BASE+idx, wdata=result word idx. After idx=3, go to WR_DONE.
- WR_DONE (1 cycle): ld=1, select=DONE_ADDR, wdata=32'h1. Then go to DONE.
- DONE:
  - select=START_ADDR, ld=0; poll the start word.
  - When reg_rdata[0]=0, go to CLR_DONE.
- CLR_DONE (1 cycle): ld=1, select=DONE_ADDR, wdata=32'h0. Then go to IDLE.
- Timing:
  - Start seen in IDLE on cycle T: key reads at T+1..T+4, message reads at T+5..T+8, aes_start on T+9, WAIT from T+10.
  - aes_done sampled on cycle D: result writes at D+1..D+4, done write at D+5.
- aes_key and aes_msg hold their values from the end of RD_MSG until the next RD_KEY/RD_MSG overwrite. They are stable throughout the AES run.
- If start stays high after completion, no restart occurs. The DONE handshake requires start to drop first.
- reg_ld is never asserted outside WR_RES, WR_DONE and CLR_DONE.

Test Plan:
- Reset then idle for 20 cycles with start word=0:
  - busy=0, reg_ld=0, reg_select=14 every cycle, aes_start never asserts.
- Key words 0..3 = 2B7E1516, 28AED2A6, ABF71588, 09CF4F3C; message words 4..7 = 3243F6A8, 885A308D, 313198A2, E0370734; then write start=1:
  - aes_key=128'h2B7E151628AED2A6ABF7158809CF4F3C.
  - aes_msg=128'h3243F6A8885A308D313198A2E0370734.
  - aes_start high for exactly one cycle, 9 cycles after start is seen.
- Model core returns aes_result=128'h3925841D02DC09FBDC118597196A0B32 after 40 cycles:
  - Words 8..11 = 3925841D, 02DC09FB, DC118597, 196A0B32 on four consecutive cycles.
  - Word 15 = 1 on the following cycle.
- With the block in DONE and start held at 1 for 10 cycles:
  - No restart, no writes.
- Then clear start:
  - Word 15 is written to 0 one cycle after start reads 0; busy=0 the cycle after that.
- aes_done pulsed during RD_MSG, then again in WAIT with a different result:
  - The first pulse is ignored; only the second result is written to words 8..11.
- Reset asserted during the second WR_RES cycle:
  - Next cycle state=IDLE, reg_ld=0, words 10..11 unwritten, word 15 unchanged.
